// File: rtl/cnn_pkg.sv
// Shared CNN types and helpers: signed data word, conv/pool map sizing and signed max.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FRAC_BIT    = 8;
  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_IMAGE_SIZE  = 28;

  typedef logic signed [DEF_DATA_WIDTH-1:0] data_t;

  function automatic int conv_size(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  function automatic int pool_size(input int conv_edge);
    return conv_edge / 2;
  endfunction

  function automatic data_t max2(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One row of horizontal pair maxima, written on even conv rows and read back on odd rows.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  data_t         wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output data_t         rd_data_o
);

  data_t mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; every entry is written on an even row before any odd-row read.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/conv_pool_stage.sv
// 2x2 stride-2 max pooling over a raster conv output stream; define POOL_RELU_EN to apply ReLU first.
module conv_pool_stage
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FRAC_BIT    = DEF_FRAC_BIT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         frame_done
);

  localparam int CONV_SIZE = conv_size(IMAGE_SIZE, KERNEL_SIZE);
  localparam int POOL_SIZE = pool_size(CONV_SIZE);
  localparam int CNT_W     = $clog2(CONV_SIZE);
  localparam int LB_AW     = CNT_W - 1;

  if (CONV_SIZE % 2 != 0) begin : g_odd_conv
    $error("conv_pool_stage: CONV_SIZE must be even");
  end
  if (DATA_WIDTH != DEF_DATA_WIDTH) begin : g_bad_width
    $error("conv_pool_stage: DATA_WIDTH must match cnn_pkg::data_t");
  end
  if (FRAC_BIT >= DATA_WIDTH) begin : g_bad_frac
    $error("conv_pool_stage: FRAC_BIT must be below DATA_WIDTH");
  end

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  data_t            pair_q, pair_d, out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  data_t            v, lb_rd_data, lb_wr_data;
  logic             lb_wr_en, col_last, row_last;

`ifdef POOL_RELU_EN
  assign v = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign v = in_data;
`endif

  assign col_last   = (col_q == CNT_W'(CONV_SIZE - 1));
  assign row_last   = (row_q == CNT_W'(CONV_SIZE - 1));
  assign lb_wr_data = max2(pair_q, v);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_wr_en     = 1'b0;
    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        pair_d = v;
      end else if (!row_q[0]) begin
        lb_wr_en = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_data_d   = max2(max2(lb_rd_data, pair_q), v);
        frame_done_d = col_last && row_last;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  pool_line_buffer #(
    .DEPTH (POOL_SIZE),
    .AW    (LB_AW)
  ) u_line_buffer (
    .clk       (clk),
    .wr_en_i   (lb_wr_en),
    .wr_addr_i (col_q[CNT_W-1:1]),
    .wr_data_i (lb_wr_data),
    .rd_addr_i (col_q[CNT_W-1:1]),
    .rd_data_o (lb_rd_data)
  );

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_pool_stage.sv
// Scoreboard bench for conv_pool_stage: a whole-frame image model predicts each pooled window.
module tb_conv_pool_stage;

  localparam int CS   = 24;
  localparam int NPIX = CS * CS;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               frame_done;

  conv_pool_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     data;
    bit     fd;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  int     got[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     img[CS][CS];
  int     pidx = 0;
  int     last_data = 0;
  int     n_out = 0;
  int     n_fd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int relu(input int x);
`ifdef POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int window_max(input int r, input int c);
    int m = img[r][c];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (img[r-dr][c-dc] > m) m = img[r-dr][c-dc];
    return m;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a pooled value.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", int'(out_data), e.data);
          check("frame_done", longint'(frame_done), longint'(e.fd));
          check("latency_cycle", cyc, e.cyc);
        end
        last_data = int'(out_data);
        got.push_back(int'(out_data));
        n_out++;
        if (frame_done === 1'b1) n_fd++;
      end else begin
        check("idle_frame_done", longint'(frame_done), 0);
        check("idle_out_data_hold", int'(out_data), last_data);
      end
    end
  end

  // Inputs change 1 time unit after each rising edge; the next edge accepts them.
  task automatic drive(input bit valid, input int data);
    logic signed [15:0] d;
    int r, c;
    d        = data[15:0];
    in_valid = valid;
    in_data  = d;
    if (valid) begin
      r = pidx / CS;
      c = pidx % CS;
      img[r][c] = relu(int'(d));
      if ((r % 2 == 1) && (c % 2 == 1))
        sb.push_back('{window_max(r, c), (r == CS-1) && (c == CS-1), cyc + 1});
      pidx = (pidx + 1) % NPIX;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, int'($urandom_range(16'hFFFF)));
  endtask

  // kind: 0 ramp, 1 all -3, 2 sparse 0x0100 marks, 3 random
  task automatic run_frame(input int kind, input bit bubbles, input int npix);
    int r, c, d;
    logic signed [15:0] rnd;
    for (int i = 0; i < npix; i++) begin
      r = i / CS;
      c = i % CS;
      if (bubbles)
        while ($urandom_range(1) == 0) idle();
      case (kind)
        0: d = r * CS + c;
        1: d = -3;
        2: d = ((r == 0 && c == 0) || (r == 1 && c == 1) || (r == 2 && c == 1) ||
                (r == 23 && c == 23)) ? 256 : 0;
        default: begin
          rnd = 16'($urandom);
          d   = int'(rnd);
        end
      endcase
      drive(1'b1, d);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      idle();
      k++;
    end
    idle();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    last_data = 0;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_frame_done", longint'(frame_done), 0);
    reset = 1'b0;
    pidx  = 0;
    sb.delete();
  endtask

  task automatic check_frames(input string name, input int out0, input int fd0, input int frames);
    check({name, "_out_count"}, n_out - out0, 144 * frames);
    check({name, "_frame_done_count"}, n_fd - fd0, frames);
  endtask

  initial begin
    int o0, f0;
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Continuous ramp
    got.delete(); o0 = n_out; f0 = n_fd;
    run_frame(0, 1'b0, NPIX);
    drain();
    check_frames("ramp", o0, f0, 1);
    if (got.size() == 144) begin
      check("ramp_first", got[0], 25);
      check("ramp_last", got[143], 575);
    end else check("ramp_got_size", got.size(), 144);

    // All-negative map
    o0 = n_out; f0 = n_fd;
    run_frame(1, 1'b0, NPIX);
    drain();
    check_frames("negative", o0, f0, 1);

    // Sparse marks: window placement
    got.delete(); o0 = n_out; f0 = n_fd;
    run_frame(2, 1'b0, NPIX);
    drain();
    check_frames("window", o0, f0, 1);
    if (got.size() == 144) begin
      check("window_p00", got[0], 256);
      check("window_p10", got[12], 256);
      check("window_p1111", got[143], 256);
      check("window_p01_zero", got[1], 0);
    end else check("window_got_size", got.size(), 144);

    // Ramp with random bubbles
    got.delete(); o0 = n_out; f0 = n_fd;
    run_frame(0, 1'b1, NPIX);
    drain();
    check_frames("bubbles", o0, f0, 1);
    if (got.size() == 144) check("bubbles_last", got[143], 575);

    // Reset after 300 pixels, then a clean ramp
    run_frame(0, 1'b0, 300);
    drain();
    do_reset();
    got.delete(); o0 = n_out; f0 = n_fd;
    run_frame(0, 1'b0, NPIX);
    drain();
    check_frames("post_reset", o0, f0, 1);
    if (got.size() == 144) check("post_reset_first", got[0], 25);

    // Back-to-back ramps
    got.delete(); o0 = n_out; f0 = n_fd;
    run_frame(0, 1'b0, NPIX);
    run_frame(0, 1'b0, NPIX);
    drain();
    check_frames("b2b", o0, f0, 2);
    if (got.size() == 288) begin
      check("b2b_second_first", got[144], 25);
      check("b2b_second_last", got[287], 575);
    end else check("b2b_got_size", got.size(), 288);

    // Random data with bubbles
    o0 = n_out; f0 = n_fd;
    run_frame(3, 1'b1, NPIX);
    drain();
    check_frames("random", o0, f0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
